stdmacro_skid_stage: RTL and testbench
======================================

// Module: stdmacro_skid_stage
// PURPOSE
//  Two-entry valid/ready pipeline stage (skid buffer) built around DFF-with-enable storage.
//  Sits between producer and consumer stages: registers every payload with full throughput.
//  s_ready is driven only from local state, which breaks the ready path combinationally.
//  Used wherever a pipeline boundary needs backpressure without a combinational ready chain.
// PARAMETERS
//  DATA_WIDTH   1   payload width in bits
// PORTS
//  clk        in   1           clock, all state updates on rising edge
//  resetn     in   1           synchronous reset, active-low
//  flush      in   1           synchronous discard of all held entries
//  s_valid    in   1           upstream payload valid
//  s_ready    out  1           stage can accept upstream payload this cycle
//  s_data     in   DATA_WIDTH  upstream payload
//  m_valid    out  1           downstream payload valid
//  m_ready    in   1           downstream accepts payload this cycle
//  m_data     out  DATA_WIDTH  downstream payload
//  occupancy  out  2           number of held entries, 0..2
// BEHAVIOUR
//  - One clock domain, single edge; reset is synchronous and active-low.
//  - Storage: main reg (drives m_data) and skid reg; each is a DFF with enable, data reset to 0.
//  - Transfer rules: accept = s_valid & s_ready; emit = m_valid & m_ready.
//  - State machine over {EMPTY, BUSY, FULL}:
//    EMPTY: accept -> BUSY, main<=s_data.
//    BUSY : accept&emit -> BUSY, main<=s_data; accept&!emit -> FULL, skid<=s_data;
//           !accept&emit -> EMPTY; else hold.
//    FULL : emit -> BUSY, main<=skid; else hold. No accept, because s_ready=0.
//  - Outputs: m_valid = (state!=EMPTY); s_ready = resetn & (state!=FULL);
//    occupancy = 0/1/2 for EMPTY/BUSY/FULL.
//  - Output source: all outputs except the reset gating of s_ready come from registers;
//    there is no combinational path from m_ready to s_ready.
//  - Latency: accepted beat is visible on m_valid/m_data the cycle after accept.
//  - Throughput: 1 beat/cycle sustained when m_ready is held high.
//  - Ordering: strictly FIFO. The skid entry is never emitted before the main entry.
//  - Payload stability: m_data stable while m_valid & !m_ready.
//  - Data regs load only on the enables listed above; no other data changes.
//  - Reset (resetn=0 at edge): state<=EMPTY, main<=0, skid<=0.
//    During reset: m_valid=0, s_ready=0, occupancy=0.
//    First cycle after reset: s_ready=1. Beats offered during reset are dropped.
//  - Flush (flush=1 at edge, resetn=1): state<=EMPTY; data regs hold their values.
//    Flush overrides any accept/emit in the same cycle.
//    The offered input beat is dropped, but it counts as handshaked because s_ready was high.
//    A beat emitted in the flush cycle is considered consumed by downstream.
//  - Precedence: reset over flush, flush over the handshake.
//  - Protocol: upstream must hold s_valid/s_data until accepted; the stage does likewise on m_*.
//    No assertion of s_valid depends on s_ready.
// TESTING
//  1 Reset: resetn=0 for 2 cycles, then 1 ->
//    during reset m_valid=0, s_ready=0, occupancy=0, m_data=0; s_ready=1 the next cycle.
//  2 Streaming, DATA_WIDTH=8: m_ready=1, send 0x01..0x10 back-to-back ->
//    m_data = 0x01..0x10 in order, one cycle later, with no bubbles.
//  3 Skid fill: send 0xA5 then 0x5A while m_ready=0 -> occupancy=2, s_ready=0, m_data=0xA5.
//    Raise m_ready -> 0xA5 then 0x5A emitted, occupancy returns 2->1->0.
//  4 Simultaneous: in BUSY with 0x33, accept 0x44 and emit in the same cycle ->
//    next cycle m_data=0x44, occupancy=1.
//  5 Flush: in FULL (0x11, 0x22) assert flush with s_valid=1 ->
//    next cycle m_valid=0, occupancy=0; neither 0x11 nor 0x22 ever appears.
//  6 Reset mid-operation: in FULL pull resetn low one cycle ->
//    EMPTY, m_valid=0, m_data=0; stored beats are never emitted.
//  All scenarios: a random m_ready/s_valid scoreboard checks in-order, loss-free delivery outside flush/reset.

Source files
------------

// File: rtl/stdmacro_skid_stage.sv
// stdmacro_skid_stage: two-entry valid/ready skid buffer with registered outputs and a registered ready.
module stdmacro_skid_stage #(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            occupancy
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]            state, state_d;
    logic [DATA_WIDTH-1:0] main_q, skid_q, main_d;
    logic                  main_en, skid_en, accept, emit;

    assign s_ready   = resetn & (state != FULL);
    assign m_valid   = state != EMPTY;
    assign m_data    = main_q;
    assign occupancy = state;
    assign accept    = s_valid & s_ready;
    assign emit      = m_valid & m_ready;

    // next state and data-register enables from the current handshake
    always_comb begin
        state_d = state;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = s_data;
        case (state)
            EMPTY: if (accept) begin
                state_d = BUSY;
                main_en = 1'b1;
            end
            BUSY: begin
                main_en = accept & emit;
                skid_en = accept & ~emit;
                state_d = (accept & ~emit) ? FULL : (~accept & emit) ? EMPTY : BUSY;
            end
            FULL: if (emit) begin
                state_d = BUSY;
                main_en = 1'b1;
                main_d  = skid_q;
            end
            default: state_d = EMPTY;
        endcase
    end

    // state register: reset beats flush, flush beats the handshake
    always_ff @(posedge clk) begin
        if (!resetn)    state <= EMPTY;
        else if (flush) state <= EMPTY;
        else            state <= state_d;
    end

    // payload registers load only on their enables; flush leaves contents alone
    always_ff @(posedge clk) begin
        if (!resetn) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (!flush) begin
            if (main_en) main_q <= main_d;
            if (skid_en) skid_q <= s_data;
        end
    end
endmodule

// File: tb/tb_stdmacro_skid_stage.sv
// tb_stdmacro_skid_stage: vector table plus scoreboard bench for the skid stage.
module tb_stdmacro_skid_stage;
    logic       clk = 1'b0;
    logic       resetn = 1'b0, flush = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready, m_valid;
    logic [7:0] m_data;
    logic [1:0] occupancy;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic       rn, sv;
        logic [7:0] sd;
        logic       mr, fl, mv, sr;
        logic [1:0] occ;
        logic [7:0] md;
    } vec_t;
    vec_t tbl[18];

    stdmacro_skid_stage #(.DATA_WIDTH(8)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic       acc, em, held;
        logic [7:0] prev, e;
        acc  = s_valid & s_ready;
        em   = resetn & m_valid & m_ready;
        held = resetn & ~flush & m_valid & ~m_ready;
        prev = m_data;
        if (em) begin
            if (sb.size() == 0) check("sb_unexpected_beat", 32'(m_data), 32'hFFFF_FFFF);
            else begin
                e = sb.pop_front();
                check("sb_order", 32'(m_data), 32'(e));
            end
        end
        if (!resetn || flush) sb.delete();
        else if (acc) sb.push_back(s_data);
        @(posedge clk);
        #1;
        if (held) begin
            check("hold_valid", 32'(m_valid), 32'd1);
            check("hold_data", 32'(m_data), 32'(prev));
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00};
        tbl[3]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 8'hA5};
        tbl[4]  = '{1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 8'hA5};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 8'h5A};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'h5A};
        tbl[7]  = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 8'h33};
        tbl[8]  = '{1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 8'h44};
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'h44};
        tbl[10] = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 8'h11};
        tbl[11] = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 8'h11};
        tbl[12] = '{1'b1, 1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 8'h11};
        tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'h11};
        tbl[14] = '{1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 8'h66};
        tbl[15] = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 8'h66};
        tbl[16] = '{1'b0, 1'b1, 8'h88, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[17] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00};

        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            resetn  = tbl[i].rn;
            s_valid = tbl[i].sv;
            s_data  = tbl[i].sd;
            m_ready = tbl[i].mr;
            flush   = tbl[i].fl;
            tick();
            check($sformatf("v%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].mv));
            check($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].sr));
            check($sformatf("v%0d_occupancy", i), 32'(occupancy), 32'(tbl[i].occ));
            check($sformatf("v%0d_m_data", i), 32'(m_data), 32'(tbl[i].md));
        end
        flush = 1'b0;

        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i);
            tick();
            check("stream_valid", 32'(m_valid), 32'd1);
            check("stream_data", 32'(m_data), 32'(i));
        end
        s_valid = 1'b0;
        tick();
        check("stream_drained", 32'(occupancy), 32'd0);

        for (int c = 0; c < 600; c++) begin
            if (!(s_valid && !s_ready)) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_data  = 8'($urandom);
            end
            m_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        check("random_drain_sb_empty", 32'(sb.size()), 32'd0);
        check("random_drain_empty", 32'(m_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
